// File: rtl/agg_pkg.sv
// Shared types and defaults for the aggregation (write-side pack) buffer.
package agg_pkg;

  localparam int DATA_WIDTH_DEF  = 16;
  localparam int FETCH_WIDTH_DEF = 4;

  // Ping-pong bank select
  typedef logic bank_idx_t;

  // Per-bank control strobes produced by the top-level handshake logic
  typedef struct packed {
    logic wr_en;   // write one element at the current column
    logic close;   // mark bank complete, latch its element count
    logic drain;   // memory took the word; bank becomes free
  } bank_ctl_t;

  // Ceiling log2 for width derivation; usable in constant expressions
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/agg_bank.sv
// One ping-pong bank: FETCH_WIDTH element slots, full flag and element count.
// Storage is cleared when the word is drained so that a word closed early
// (partial flush) reads zero in the slots that were never written.
module agg_bank
  import agg_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int FETCH_WIDTH = FETCH_WIDTH_DEF,
  parameter int IW          = clog2(FETCH_WIDTH),
  parameter int CW          = IW + 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  bank_ctl_t                             ctl,
  input  logic [IW-1:0]                         wr_col,
  input  logic [DATA_WIDTH-1:0]                 wr_data,
  input  logic [CW-1:0]                         close_cnt,
  output logic                                  full,
  output logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] data,
  output logic [CW-1:0]                         count
);

  // Element storage: clear on drain, then a same-cycle write (never to a
  // draining bank in practice) lands on top of the cleared word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else begin
      if (ctl.drain) data <= '0;
      if (ctl.wr_en) data[wr_col] <= wr_data;
    end
  end

  // Full flag and recorded element count; close and drain never target the
  // same bank in one cycle (close needs it empty, drain needs it full).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full  <= 1'b0;
      count <= '0;
    end else if (ctl.close) begin
      full  <= 1'b1;
      count <= close_cnt;
    end else if (ctl.drain) begin
      full  <= 1'b0;
      count <= '0;
    end
  end

endmodule

// File: rtl/agg_buffer.sv
// Aggregation buffer: packs one-per-cycle stream elements into
// FETCH_WIDTH-wide memory words, ping-pong double buffered.
// Optional feature macro AGG_FLUSH_EN adds flush (early close of a partial
// word) and mem_count (valid elements in mem_data).
module agg_buffer
  import agg_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int FETCH_WIDTH = FETCH_WIDTH_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_WIDTH-1:0]             data_in,
  input  logic                              valid_in,
  output logic                              ready_in,
  output logic [FETCH_WIDTH*DATA_WIDTH-1:0] mem_data,
  output logic                              mem_valid,
  input  logic                              mem_ready
`ifdef AGG_FLUSH_EN
  ,
  input  logic                              flush,
  output logic [$clog2(FETCH_WIDTH):0]      mem_count
`endif
);

  localparam int IW = clog2(FETCH_WIDTH);
  localparam int CW = IW + 1;

  logic [IW-1:0]   col_index;
  bank_idx_t       wr_bank;
  bank_idx_t       rd_bank;

  logic [1:0]                                  full;
  logic [1:0][FETCH_WIDTH-1:0][DATA_WIDTH-1:0] bank_data;
  logic [1:0][CW-1:0]                          bank_cnt;
  bank_ctl_t [1:0]                             ctl;

  logic          accept;
  logic          last;
  logic          close;
  logic          drain;
  logic [CW-1:0] close_cnt;

  // Handshake: input side only sees the registered full flag of its bank
  assign ready_in  = ~full[wr_bank];
  assign accept    = valid_in & ready_in;
  assign last      = accept & (col_index == IW'(FETCH_WIDTH - 1));

`ifdef AGG_FLUSH_EN
  logic flush_close;
  // Early close only when there is something to close (old or incoming data)
  assign flush_close = flush & ready_in & ((col_index != '0) | accept);
  assign close       = last | flush_close;
`else
  assign close       = last;
`endif

  // Elements in the word being closed, including a same-cycle accept
  assign close_cnt = CW'(col_index) + CW'(accept);

  // Output side is pure register read of the bank under rd_bank
  assign mem_valid = full[rd_bank];
  assign mem_data  = bank_data[rd_bank];
  assign drain     = mem_valid & mem_ready;

`ifdef AGG_FLUSH_EN
  assign mem_count = mem_valid ? bank_cnt[rd_bank] : '0;
`endif

  // Two banks; strobes steered by the write and read pointers
  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign ctl[b].wr_en = accept & (wr_bank == bank_idx_t'(b));
    assign ctl[b].close = close  & (wr_bank == bank_idx_t'(b));
    assign ctl[b].drain = drain  & (rd_bank == bank_idx_t'(b));

    agg_bank #(
      .DATA_WIDTH  (DATA_WIDTH),
      .FETCH_WIDTH (FETCH_WIDTH),
      .IW          (IW),
      .CW          (CW)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .ctl       (ctl[b]),
      .wr_col    (col_index),
      .wr_data   (data_in),
      .close_cnt (close_cnt),
      .full      (full[b]),
      .data      (bank_data[b]),
      .count     (bank_cnt[b])
    );
  end

  // Column counter and write pointer advance on accept / close
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_index <= '0;
      wr_bank   <= 1'b0;
    end else if (close) begin
      col_index <= '0;
      wr_bank   <= ~wr_bank;
    end else if (accept) begin
      col_index <= col_index + IW'(1);
    end
  end

  // Read pointer follows completed drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank <= 1'b0;
    end else if (drain) begin
      rd_bank <= ~rd_bank;
    end
  end

  // A word offered to memory must not change until it is taken
  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (mem_valid && !mem_ready) |=> (mem_valid && $stable(mem_data)));

`ifndef AGG_FLUSH_EN
  // Without flush every emitted word is complete
  a_full_word: assert property (@(posedge clk) disable iff (!rst_n)
    mem_valid |-> (bank_cnt[rd_bank] == CW'(FETCH_WIDTH)));
`endif

endmodule

// File: tb/tb_agg_buffer.sv
// Self-checking bench for agg_buffer (DATA_WIDTH=16, FETCH_WIDTH=4).
module tb_agg_buffer;

  localparam int DW = 16;
  localparam int FW = 4;

  logic             clk;
  logic             rst_n;
  logic [DW-1:0]    data_in;
  logic             valid_in;
  logic             ready_in;
  logic [FW*DW-1:0] mem_data;
  logic             mem_valid;
  logic             mem_ready;
`ifdef AGG_FLUSH_EN
  logic             flush;
  logic [2:0]       mem_count;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  agg_buffer #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .mem_data  (mem_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready)
`ifdef AGG_FLUSH_EN
    ,
    .flush     (flush),
    .mem_count (mem_count)
`endif
  );

  typedef struct {
    logic [63:0] data;
    int          cnt;
  } word_t;

  typedef struct {
    bit          v;
    logic [15:0] d;
    bit          mr;
    bit          er;
    bit          emv;
  } vec_t;

  word_t               sb[$];
  logic [FW-1:0][DW-1:0] part;
  int                  pcnt;
  int                  n_chk;
  int                  n_fail;
  int                  n_drain;
  int                  n_stall;
  vec_t                tbl[19];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    part = '0;
    pcnt = 0;
  endtask

  // One clock: drive at posedge+1, check and advance the model at negedge.
  // er/emv < 0 means no table expectation for this cycle.
  task automatic step(input bit v, input logic [15:0] d, input bit mr, input bit fl,
                      input int er, input int emv);
    bit exp_rdy, exp_vld, acc, drn, fl_close;
    valid_in  = v;
    data_in   = d;
    mem_ready = mr;
`ifdef AGG_FLUSH_EN
    flush     = fl;
`endif
    @(negedge clk);
    exp_rdy = (sb.size() < 2);
    exp_vld = (sb.size() > 0);
    chk("ready_in", 64'(ready_in), 64'(exp_rdy));
    chk("mem_valid", 64'(mem_valid), 64'(exp_vld));
    if (er >= 0)  chk("tbl_ready_in", 64'(ready_in), 64'(er));
    if (emv >= 0) chk("tbl_mem_valid", 64'(mem_valid), 64'(emv));
    if (exp_vld) begin
      chk("mem_data", mem_data, sb[0].data);
`ifdef AGG_FLUSH_EN
      chk("mem_count", 64'(mem_count), 64'(sb[0].cnt));
    end else begin
      chk("mem_count_idle", 64'(mem_count), 64'd0);
`endif
    end
    if (!ready_in) n_stall++;
    acc = v & exp_rdy;
    drn = exp_vld & mr;
    if (drn) begin
      void'(sb.pop_front());
      n_drain++;
    end
    if (acc) begin
      part[pcnt] = d;
      pcnt++;
    end
    fl_close = fl && exp_rdy && (pcnt != 0);
    if ((acc && pcnt == FW) || fl_close) begin
      sb.push_back('{part, pcnt});
      part = '0;
      pcnt = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit mr);
    step(1'b0, 16'h0, mr, 1'b0, -1, -1);
  endtask

  int d0;

  initial begin
    n_chk = 0; n_fail = 0; n_drain = 0; n_stall = 0;
    model_clear();
    rst_n = 1'b0; valid_in = 1'b0; data_in = '0; mem_ready = 1'b0;
`ifdef AGG_FLUSH_EN
    flush = 1'b0;
`endif

    // Test 2 vectors: fill both banks with memory stalled, hold 9th element
    tbl[0]  = '{1'b1, 16'h0011, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 16'h0012, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 16'h0013, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 16'h0014, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 16'h0021, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 16'h0022, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 16'h0023, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 16'h0024, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 16'h0031, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 16'h0031, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 16'h0031, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 16'h0031, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 16'h0032, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 16'h0033, 1'b1, 1'b1, 1'b0};
    tbl[16] = '{1'b1, 16'h0034, 1'b1, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    tbl[18] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_in", 64'(ready_in), 64'd1);
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_mem_data", mem_data, 64'd0);
`ifdef AGG_FLUSH_EN
    chk("rst_mem_count", 64'(mem_count), 64'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: simple word, visible the cycle after the 4th accept
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 1'b1, 1'b0, -1, -1);
    chk("t1_valid", 64'(mem_valid), 64'd1);
    chk("t1_word", mem_data, 64'h0004_0003_0002_0001);
    idle(1'b1);
    idle(1'b1);

    // Test 2: table-driven stall / ordered drain
    for (int i = 0; i < 19; i++)
      step(tbl[i].v, tbl[i].d, tbl[i].mr, 1'b0, int'(tbl[i].er), int'(tbl[i].emv));

    // Test 3: sustained throughput, 16 elements -> 4 words, no stalls
    n_stall = 0;
    d0 = n_drain;
    for (int i = 0; i < 16; i++) step(1'b1, 16'(16'h0100 + i), 1'b1, 1'b0, -1, -1);
    idle(1'b1);
    chk("t3_drains", 64'(n_drain - d0), 64'd4);
    chk("t3_stalls", 64'(n_stall), 64'd0);

    // Test 6: word held stable while memory stalls
    for (int i = 0; i < 4; i++) step(1'b1, 16'(16'h00C0 + i), 1'b0, 1'b0, -1, -1);
    for (int i = 0; i < 2; i++) begin
      chk("t6_hold", mem_data, 64'h00C3_00C2_00C1_00C0);
      idle(1'b0);
    end
    chk("t6_hold_last", mem_data, 64'h00C3_00C2_00C1_00C0);
    idle(1'b1);
    idle(1'b1);

    // Test 4: reset with a pending word and a partial word
    for (int i = 0; i < 6; i++) step(1'b1, 16'(16'h00E0 + i), 1'b0, 1'b0, -1, -1);
    valid_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_ready_in", 64'(ready_in), 64'd1);
    chk("t4_mem_valid", 64'(mem_valid), 64'd0);
    chk("t4_mem_data", mem_data, 64'd0);
`ifdef AGG_FLUSH_EN
    chk("t4_mem_count", 64'(mem_count), 64'd0);
`endif
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(16'h00D0 + i), 1'b1, 1'b0, -1, -1);
    chk("t4_word", mem_data, 64'h00D4_00D3_00D2_00D1);
    idle(1'b1);
    idle(1'b1);

`ifdef AGG_FLUSH_EN
    // Test 5: partial flush, empty flush, flush with same-cycle accept
    step(1'b1, 16'h000A, 1'b0, 1'b0, -1, -1);
    step(1'b1, 16'h000B, 1'b0, 1'b0, -1, -1);
    step(1'b0, 16'h0000, 1'b0, 1'b1, -1, -1);
    chk("t5_word", mem_data, 64'h0000_0000_000B_000A);
    chk("t5_count", 64'(mem_count), 64'd2);
    idle(1'b1);
    step(1'b0, 16'h0000, 1'b1, 1'b1, -1, -1);
    chk("t5_empty_flush", 64'(mem_valid), 64'd0);
    step(1'b1, 16'h000E, 1'b1, 1'b1, -1, -1);
    chk("t5_acc_flush", mem_data, 64'h0000_0000_0000_000E);
    chk("t5_acc_count", 64'(mem_count), 64'd1);
    idle(1'b1);
    idle(1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
